// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
//   EX-stage branch resolution and dynamic branch predictor for the RV32 pipe.
//   A resolved branch is compared with the prediction IF made for it. The
//   2-bit result code, the redirect pulse and the redirect PC are registered,
//   so IF sees them one cycle after capture. The block also holds a
//   direct-mapped branch table (valid, tag, target, 2-bit counter). IF looks
//   the table up combinationally. Saturating statistics counters record
//   resolved branches and mispredicts.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   if_pc             fetch PC looked up in the table
//   if_pred_taken     hit && counter MSB
//   if_pred_target    table target on a hit, otherwise if_pc+4
//   ex_valid          resolved branch/jump present in EX
//   ex_pc             PC of the resolved instruction
//   ex_predicted      taken prediction carried down from IF
//   ex_pc_pre         target prediction carried down from IF
//   ex_taken          actual outcome
//   ex_pc_alu         actual target from the ALU
//   bht_clear         invalidates every table entry on the next edge
//   result            00 wrong target, 01 correct, 10 go PC+4, 11 go PC_ALU
//   redirect          one-cycle pulse on a mispredict
//   redirect_pc       fetch address that goes with redirect
//   stat_branches     saturating count of resolved branches
//   stat_mispredicts  saturating count of redirects
// -----------------------------------------------------------------------------
module branch_resolve_unit #(
  parameter int WIDTH_DATA_LENGTH = 32,
  parameter int BHT_ENTRIES       = 16,
  parameter int IDX_LSB           = 2,
  parameter int STAT_WIDTH        = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WIDTH_DATA_LENGTH-1:0] if_pc,
  output logic                         if_pred_taken,
  output logic [WIDTH_DATA_LENGTH-1:0] if_pred_target,
  input  logic                         ex_valid,
  input  logic [WIDTH_DATA_LENGTH-1:0] ex_pc,
  input  logic                         ex_predicted,
  input  logic [WIDTH_DATA_LENGTH-1:0] ex_pc_pre,
  input  logic                         ex_taken,
  input  logic [WIDTH_DATA_LENGTH-1:0] ex_pc_alu,
  input  logic                         bht_clear,
  output logic [1:0]                   result,
  output logic                         redirect,
  output logic [WIDTH_DATA_LENGTH-1:0] redirect_pc,
  output logic [STAT_WIDTH-1:0]        stat_branches,
  output logic [STAT_WIDTH-1:0]        stat_mispredicts
);

  localparam int W        = WIDTH_DATA_LENGTH;
  localparam int IDX_BITS = $clog2(BHT_ENTRIES);
  localparam int TAG_LSB  = IDX_LSB + IDX_BITS;
  localparam int TAG_BITS = W - TAG_LSB;

  localparam logic [1:0]            CODE_WRONG_TGT = 2'b00;
  localparam logic [1:0]            CODE_CORRECT   = 2'b01;
  localparam logic [1:0]            CODE_GO_SEQ    = 2'b10;
  localparam logic [1:0]            CODE_GO_ALU    = 2'b11;
  localparam logic [STAT_WIDTH-1:0] STAT_MAX       = '1;

  logic                valid_q  [BHT_ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [BHT_ENTRIES];
  logic [W-1:0]        target_q [BHT_ENTRIES];
  logic [1:0]          cnt_q    [BHT_ENTRIES];

  logic [IDX_BITS-1:0] if_idx, ex_idx;
  logic [TAG_BITS-1:0] if_tag, ex_tag;
  logic                if_hit, ex_hit;
  logic [1:0]          code;
  logic [W-1:0]        next_redirect_pc;

  // The low PC bits below the index are always zero for word-aligned code,
  // so the table never looks at them.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[IDX_LSB-1:0], ex_pc[IDX_LSB-1:0]};

  assign if_idx = if_pc[TAG_LSB-1:IDX_LSB];
  assign if_tag = if_pc[W-1:TAG_LSB];
  assign ex_idx = ex_pc[TAG_LSB-1:IDX_LSB];
  assign ex_tag = ex_pc[W-1:TAG_LSB];

  // The lookup reads the registered table. An update to the same entry in
  // this cycle is therefore not visible until the next cycle.
  assign if_hit         = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign ex_hit         = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign if_pred_taken  = if_hit && cnt_q[if_idx][1];
  assign if_pred_target = if_hit ? target_q[if_idx] : (if_pc + W'(4));

  // Result classification.
  // When the branch was predicted taken and is actually taken, only the
  // target decides whether the fetch was right.
  always_comb begin
    code = CODE_CORRECT;
    unique case ({ex_taken, ex_predicted})
      2'b00:   code = CODE_CORRECT;
      2'b01:   code = CODE_GO_SEQ;
      2'b10:   code = CODE_GO_ALU;
      default: code = (ex_pc_pre != ex_pc_alu) ? CODE_WRONG_TGT : CODE_CORRECT;
    endcase
  end

  assign next_redirect_pc = (code == CODE_GO_SEQ) ? (ex_pc + W'(4)) : ex_pc_alu;

  // Registered result and redirect.
  // The redirect pulse lasts one cycle. Its result code and PC stay on the
  // outputs until the next resolved branch replaces them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result      <= CODE_CORRECT;
      redirect    <= 1'b0;
      redirect_pc <= '0;
    end else if (ex_valid) begin
      result      <= code;
      redirect    <= (code != CODE_CORRECT);
      redirect_pc <= next_redirect_pc;
    end else begin
      redirect    <= 1'b0;
    end
  end

  // Statistics counters saturate at all-ones and never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (ex_valid) begin
      if (stat_branches != STAT_MAX)
        stat_branches <= stat_branches + 1'b1;
      if ((code != CODE_CORRECT) && (stat_mispredicts != STAT_MAX))
        stat_mispredicts <= stat_mispredicts + 1'b1;
    end
  end

  // Branch table.
  // bht_clear takes priority over a training update in the same cycle. A
  // not-taken branch that misses leaves the table alone, so it does not
  // evict a useful entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= 2'b01;
      end
    end else if (bht_clear) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= 2'b01;
      end
    end else if (ex_valid) begin
      if (ex_taken) begin
        if (ex_hit) begin
          if (cnt_q[ex_idx] != 2'b11)
            cnt_q[ex_idx] <= cnt_q[ex_idx] + 2'b01;
          target_q[ex_idx] <= ex_pc_alu;
        end else begin
          valid_q[ex_idx]  <= 1'b1;
          tag_q[ex_idx]    <= ex_tag;
          target_q[ex_idx] <= ex_pc_alu;
          cnt_q[ex_idx]    <= 2'b10;
        end
      end else if (ex_hit && (cnt_q[ex_idx] != 2'b00)) begin
        cnt_q[ex_idx] <= cnt_q[ex_idx] - 2'b01;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  localparam int W   = 32;
  localparam int N   = 16;
  localparam int LSB = 2;
  localparam int IB  = 4;
  localparam int SW  = 4;
  localparam int STAT_MAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  if_pc = '0;
  logic          if_pred_taken;
  logic [W-1:0]  if_pred_target;
  logic          ex_valid = 1'b0;
  logic [W-1:0]  ex_pc = '0;
  logic          ex_predicted = 1'b0;
  logic [W-1:0]  ex_pc_pre = '0;
  logic          ex_taken = 1'b0;
  logic [W-1:0]  ex_pc_alu = '0;
  logic          bht_clear = 1'b0;
  logic [1:0]    result;
  logic          redirect;
  logic [W-1:0]  redirect_pc;
  logic [SW-1:0] stat_branches;
  logic [SW-1:0] stat_mispredicts;

  int assert_count = 0;
  int fail_count   = 0;

  // Reference model of the table, kept as plain per-entry values
  bit          m_valid  [N];
  int unsigned m_tag    [N];
  logic [31:0] m_target [N];
  int          m_cnt    [N];
  logic [1:0]  exp_result;
  logic        exp_redirect;
  logic [31:0] exp_rpc;
  int          exp_br, exp_mp;

  branch_resolve_unit #(
    .WIDTH_DATA_LENGTH(W), .BHT_ENTRIES(N), .IDX_LSB(LSB), .STAT_WIDTH(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_pc(if_pc), .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_predicted(ex_predicted),
    .ex_pc_pre(ex_pc_pre), .ex_taken(ex_taken), .ex_pc_alu(ex_pc_alu),
    .bht_clear(bht_clear), .result(result), .redirect(redirect),
    .redirect_pc(redirect_pc), .stat_branches(stat_branches),
    .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int unsigned idxOf(input logic [31:0] pc);
    return (pc >> LSB) % N;
  endfunction

  function automatic int unsigned tagOf(input logic [31:0] pc);
    return pc >> (LSB + IB);
  endfunction

  function automatic bit modelHit(input logic [31:0] pc);
    return m_valid[idxOf(pc)] && (m_tag[idxOf(pc)] == tagOf(pc));
  endfunction

  task automatic modelReset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_target[i] = '0; m_cnt[i] = 1;
    end
    exp_result = 2'b01; exp_redirect = 1'b0; exp_rpc = '0;
    exp_br = 0; exp_mp = 0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkLookup(input logic [31:0] pc);
    logic [31:0] seq;
    bit hit;
    seq = pc + 32'd4;
    if_pc = pc;
    #1;
    hit = modelHit(pc);
    checkOutput("pred_taken", {31'b0, if_pred_taken}, {31'b0, hit && (m_cnt[idxOf(pc)] >= 2)});
    checkOutput("pred_target", if_pred_target, hit ? m_target[idxOf(pc)] : seq);
  endtask

  task automatic checkRegs();
    checkOutput("result", {30'b0, result}, {30'b0, exp_result});
    checkOutput("redirect", {31'b0, redirect}, {31'b0, exp_redirect});
    checkOutput("redirect_pc", redirect_pc, exp_rpc);
    checkOutput("stat_branches", {28'b0, stat_branches}, exp_br);
    checkOutput("stat_mispredicts", {28'b0, stat_mispredicts}, exp_mp);
  endtask

  // Drive one EX cycle, check the lookup of the same PC before the edge and
  // the registered outputs after it
  task automatic applyStimulus(input bit v, input logic [31:0] pc, input bit pred,
                               input logic [31:0] pre, input bit taken,
                               input logic [31:0] alu, input bit clr);
    logic [1:0] code;
    int unsigned i;
    @(negedge clk);
    ex_valid = v; ex_pc = pc; ex_predicted = pred; ex_pc_pre = pre;
    ex_taken = taken; ex_pc_alu = alu; bht_clear = clr;
    checkLookup(pc);
    if (!taken && !pred)      code = 2'b01;
    else if (!taken && pred)  code = 2'b10;
    else if (taken && !pred)  code = 2'b11;
    else                      code = (pre == alu) ? 2'b01 : 2'b00;
    @(posedge clk);
    #1;
    ex_valid = 1'b0; bht_clear = 1'b0;
    if (v) begin
      exp_result   = code;
      exp_redirect = (code != 2'b01);
      exp_rpc      = (code == 2'b10) ? pc + 32'd4 : alu;
      if (exp_br < STAT_MAX) exp_br++;
      if (exp_redirect && exp_mp < STAT_MAX) exp_mp++;
    end else begin
      exp_redirect = 1'b0;
    end
    i = idxOf(pc);
    if (clr) begin
      for (int k = 0; k < N; k++) begin m_valid[k] = 0; m_cnt[k] = 1; end
    end else if (v && taken) begin
      if (modelHit(pc)) begin
        m_cnt[i] = (m_cnt[i] + 1 > 3) ? 3 : m_cnt[i] + 1;
        m_target[i] = alu;
      end else begin
        m_valid[i] = 1; m_tag[i] = tagOf(pc); m_target[i] = alu; m_cnt[i] = 2;
      end
    end else if (v && modelHit(pc)) begin
      m_cnt[i] = (m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1;
    end
    checkRegs();
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    modelReset();
    checkRegs();
    for (int k = 0; k < N; k++) checkLookup(32'h100 + 32'(k * 4));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [31:0] pool [8];
  bit          cnt_seq [7];

  initial begin
    logic [31:0] pc, alu, pre;
    bit pred, taken, v, clr;
    int unsigned r;

    pool[0] = 32'h100; pool[1] = 32'h140; pool[2] = 32'h180; pool[3] = 32'h1C0;
    pool[4] = 32'h104; pool[5] = 32'h2000; pool[6] = 32'hFFFF_FFFC; pool[7] = 32'h144;
    cnt_seq[0] = 1; cnt_seq[1] = 1; cnt_seq[2] = 1;
    cnt_seq[3] = 1; cnt_seq[4] = 0; cnt_seq[5] = 0; cnt_seq[6] = 0;

    modelReset();
    doReset();

    $display("[TB] directed classification");
    applyStimulus(1, 32'h100, 0, 32'h0, 1, 32'h200, 0);
    checkOutput("dir_result_11", {30'b0, result}, 32'h3);
    checkOutput("dir_redirect_11", {31'b0, redirect}, 32'h1);
    checkOutput("dir_rpc_200", redirect_pc, 32'h200);
    checkLookup(32'h100);
    checkOutput("dir_lookup_taken", {31'b0, if_pred_taken}, 32'h1);
    checkOutput("dir_lookup_target", if_pred_target, 32'h200);
    applyStimulus(0, 32'h100, 0, 32'h0, 0, 32'h0, 0);
    checkOutput("dir_pulse_drop", {31'b0, redirect}, 32'h0);
    applyStimulus(1, 32'h100, 1, 32'h200, 1, 32'h240, 0);
    checkOutput("dir_result_00", {30'b0, result}, 32'h0);
    checkOutput("dir_rpc_240", redirect_pc, 32'h240);
    applyStimulus(1, 32'h100, 1, 32'h240, 0, 32'h240, 0);
    checkOutput("dir_result_10", {30'b0, result}, 32'h2);
    checkOutput("dir_rpc_104", redirect_pc, 32'h104);
    applyStimulus(1, 32'h100, 0, 32'h0, 0, 32'h104, 0);
    checkOutput("dir_result_01", {30'b0, result}, 32'h1);
    checkOutput("dir_no_redirect", {31'b0, redirect}, 32'h0);

    $display("[TB] counter saturation and aliasing");
    doReset();
    for (int k = 0; k < 7; k++) begin
      applyStimulus(1, 32'h100, 0, 32'h0, (k < 3), 32'h200, 0);
      checkLookup(32'h100);
      checkOutput("cnt_seq", {31'b0, if_pred_taken}, {31'b0, cnt_seq[k]});
    end
    checkLookup(32'h140);
    checkOutput("alias_miss_target", if_pred_target, 32'h144);
    applyStimulus(1, 32'h140, 0, 32'h0, 1, 32'h300, 0);
    checkLookup(32'h140);
    checkOutput("alias_new_target", if_pred_target, 32'h300);
    checkLookup(32'h100);
    checkOutput("alias_old_evicted", if_pred_target, 32'h104);

    $display("[TB] clear with simultaneous update");
    applyStimulus(1, 32'h180, 0, 32'h0, 1, 32'h400, 0);
    applyStimulus(1, 32'h1C0, 0, 32'h0, 1, 32'h500, 1);
    checkLookup(32'h180);
    checkOutput("clear_miss", {31'b0, if_pred_taken}, 32'h0);
    checkLookup(32'h1C0);
    checkOutput("clear_beats_update", if_pred_target, 32'h1C4);

    $display("[TB] statistics saturation and PC wrap");
    doReset();
    for (int k = 0; k < 20; k++)
      applyStimulus(1, 32'h100 + 32'(k * 4), 0, 32'h0, 1, 32'h800, 0);
    checkOutput("stat_br_sat", {28'b0, stat_branches}, 32'hF);
    checkOutput("stat_mp_sat", {28'b0, stat_mispredicts}, 32'hF);
    applyStimulus(1, 32'hFFFF_FFFC, 1, 32'h10, 0, 32'h10, 0);
    checkOutput("wrap_rpc", redirect_pc, 32'h0);
    checkLookup(32'hFFFF_FFFC);
    checkOutput("wrap_lookup", if_pred_target, 32'h0);

    $display("[TB] random traffic");
    doReset();
    for (int k = 0; k < 300; k++) begin
      r     = $urandom;
      pc    = (r[3]) ? pool[r[2:0]] : {$urandom_range(0, 32'h3FFF), 2'b00};
      v     = ($urandom_range(0, 7) != 0);
      pred  = $urandom_range(0, 1);
      taken = $urandom_range(0, 1);
      alu   = {$urandom_range(0, 255), 2'b00};
      pre   = $urandom_range(0, 1) ? alu : {$urandom_range(0, 255), 2'b00};
      clr   = ($urandom_range(0, 31) == 0);
      applyStimulus(v, pc, pred, pre, taken, alu, clr);
      checkLookup(pool[$urandom_range(0, 7)]);
      if (k == 150) doReset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
